// File: rtl/digit_scan_decoder_if.sv
// Bundle between the BCD/count registers (master) and the digit scan decoder (slave).
interface digit_scan_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SEL_WIDTH  = 2
);
  logic                           enable;
  logic                           lz_blank;
  logic [NUM_DIGITS-1:0][3:0]     digit_data;
  logic [NUM_DIGITS-1:0]          dp_in;
  logic [NUM_DIGITS-1:0]          digit_en;
  logic [SEL_WIDTH-1:0]           sel;
  logic [3:0]                     nibble_out;
  logic                           dp_out;
  logic                           blank_out;
  logic                           scan_tick;

  modport master (
    output enable, lz_blank, digit_data, dp_in,
    input  digit_en, sel, nibble_out, dp_out, blank_out, scan_tick
  );

  modport slave (
    input  enable, lz_blank, digit_data, dp_in,
    output digit_en, sel, nibble_out, dp_out, blank_out, scan_tick
  );
endinterface

// File: rtl/digit_scan_decoder.sv
// Time-multiplexed seven-segment digit scanner: dwell/blank sequencing, per-digit
// nibble/dp capture and leading-zero suppression, all outputs registered.
module digit_scan_decoder #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  digit_scan_decoder_if.slave  bus
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]         BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [SEL_WIDTH-1:0]  SEL_LAST   = SEL_WIDTH'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF     = ACTIVE_LOW ? '1 : '0;

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [3:0]              nib_q, nib_d;
  logic                    dp_q, dp_d;
  logic                    blank_q, blank_d;
  logic                    tick_q, tick_d;

  logic                    dwell_done, blank_done, enter_drive;
  logic [NUM_DIGITS-1:0]   zero_from, onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= EN_OFF;
      nib_q   <= '0;
      dp_q    <= 1'b0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      nib_q   <= nib_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  // With no blanking gap, BLANK (after reset/disable) lasts a single cycle.
  always_comb begin
    dwell_done  = (cnt_q == DWELL_LAST);
    blank_done  = (BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST);
    enter_drive = bus.enable &&
                  (((state_q == BLANK) && blank_done) ||
                   ((state_q == DRIVE) && dwell_done && (BLANK_CYCLES == 0)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    sel_d   = sel_q;
    if (!bus.enable) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK: if (blank_done) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
        DRIVE: if (dwell_done) begin
          cnt_d   = '0;
          sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_WIDTH'(1);
          state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        end
        default: state_d = BLANK;
      endcase
    end
  end

  // zero_from[i]: digit i and every more-significant digit are zero.
  always_comb begin
    zero_from = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      for (int j = i; j < NUM_DIGITS; j++)
        if (bus.digit_data[j] != 4'd0) zero_from[i] = 1'b0;
  end

  always_comb begin
    en_d    = en_q;
    nib_d   = nib_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    onehot  = '0;
    tick_d  = bus.enable && (state_q == DRIVE) && dwell_done && (sel_q == SEL_LAST);
    if (!bus.enable) begin
      en_d    = EN_OFF;
      blank_d = 1'b1;
    end else if (enter_drive) begin
      // Suppressed digits keep digit_en asserted so brightness duty stays constant.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_d == SEL_WIDTH'(i)) begin
          onehot[i] = 1'b1;
          nib_d     = bus.digit_data[i];
          dp_d      = bus.dp_in[i];
          blank_d   = bus.lz_blank && (i != 0) && zero_from[i];
        end
      end
      en_d = onehot ^ EN_OFF;
    end else if ((state_q == DRIVE) && dwell_done) begin
      en_d    = EN_OFF;
      blank_d = 1'b1;
    end
  end

  assign bus.digit_en   = en_q;
  assign bus.sel        = sel_q;
  assign bus.nibble_out = nib_q;
  assign bus.dp_out     = dp_q;
  assign bus.blank_out  = blank_q;
  assign bus.scan_tick  = tick_q;

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Scoreboard bench: three decoder configurations share one stimulus; expected
// per-cycle outputs are queued by the stimulus and popped by a negedge monitor.
module tb_digit_scan_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic lz = 1'b1;
  logic [15:0] data = 16'h0407;
  logic [3:0]  dp = 4'b0010;

  always #5 clk = ~clk;

  // id 0: D=4 B=2 active-low, id 1: D=3 B=0 active-high, id 2: D=4 B=2 active-high
  digit_scan_decoder_if #(.NUM_DIGITS(4), .SEL_WIDTH(2)) ifa ();
  digit_scan_decoder_if #(.NUM_DIGITS(4), .SEL_WIDTH(2)) ifb ();
  digit_scan_decoder_if #(.NUM_DIGITS(4), .SEL_WIDTH(2)) ifc ();

  assign ifa.enable = enable;  assign ifa.lz_blank = lz;
  assign ifa.digit_data = data; assign ifa.dp_in = dp;
  assign ifb.enable = enable;  assign ifb.lz_blank = lz;
  assign ifb.digit_data = data; assign ifb.dp_in = dp;
  assign ifc.enable = enable;  assign ifc.lz_blank = lz;
  assign ifc.digit_data = data; assign ifc.dp_in = dp;

  digit_scan_decoder #(.NUM_DIGITS(4), .SEL_WIDTH(2), .DWELL_CYCLES(4),
                       .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1))
    u_a (.clk(clk), .reset(reset), .bus(ifa));
  digit_scan_decoder #(.NUM_DIGITS(4), .SEL_WIDTH(2), .DWELL_CYCLES(3),
                       .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0))
    u_b (.clk(clk), .reset(reset), .bus(ifb));
  digit_scan_decoder #(.NUM_DIGITS(4), .SEL_WIDTH(2), .DWELL_CYCLES(4),
                       .BLANK_CYCLES(2), .ACTIVE_LOW(1'b0))
    u_c (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct {
    int         t;
    int         id;
    logic [3:0] en;
    logic [1:0] sel;
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic       tick;
    logic       chk_data;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          base = 0;
  int          checks = 0;
  int          errors = 0;
  logic [20:0] hist [0:63];   // {lz, dp, data} present during each phase cycle

  always @(posedge clk) cyc <= cyc + 1;

  // Closed-form timing of a free-running scan started from reset at phase cycle 0.
  function automatic exp_t model(int id, int t, int dw, int bl, bit al);
    exp_t e;
    int k, digit, start;
    bit drv;
    logic [20:0] h;
    logic [3:0] oh;
    e.t = base + t; e.id = id; e.tick = 1'b0; e.chk_data = 1'b0;
    e.nib = 4'h0; e.dp = 1'b0; e.blank = 1'b1;
    if (bl > 0) begin
      k = t / (dw + bl); digit = k % 4; drv = (t % (dw + bl)) >= bl;
      start = k * (dw + bl) + bl;
      e.tick = (t > 0) && (t % (4 * (dw + bl)) == 0);
    end else if (t == 0) begin
      digit = 0; drv = 1'b0; start = 1;
    end else begin
      k = (t - 1) / dw; digit = k % 4; drv = 1'b1; start = 1 + k * dw;
      e.tick = (t > 1) && ((t - 1) % (4 * dw) == 0);
    end
    oh = drv ? 4'(1 << digit) : 4'b0000;
    e.en = al ? ~oh : oh;
    e.sel = 2'(digit);
    if (t == 0) begin
      e.chk_data = 1'b1;
    end else if (drv) begin
      h = hist[start - 1];
      e.chk_data = 1'b1;
      e.nib = h[4*digit +: 4];
      e.dp = h[16 + digit];
      e.blank = h[20] && (digit > 0) && ((h[15:0] >> (4 * digit)) == 16'h0);
    end
    return e;
  endfunction

  task automatic push_a(int rel, logic [3:0] en, logic [1:0] sel, logic blank,
                        logic tick, logic chk, logic [3:0] nib, logic dpv);
    exp_t e;
    e.t = base + rel; e.id = 0; e.en = en; e.sel = sel; e.blank = blank;
    e.tick = tick; e.chk_data = chk; e.nib = nib; e.dp = dpv;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    base = cyc;
    reset = 1'b0;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].t <= cyc) begin
      exp_t e;
      logic [3:0] en; logic [1:0] sel; logic [3:0] nib; logic dpo, bl, tk;
      bit bad;
      e = q.pop_front();
      case (e.id)
        0: begin en = ifa.digit_en; sel = ifa.sel; nib = ifa.nibble_out;
                 dpo = ifa.dp_out; bl = ifa.blank_out; tk = ifa.scan_tick; end
        1: begin en = ifb.digit_en; sel = ifb.sel; nib = ifb.nibble_out;
                 dpo = ifb.dp_out; bl = ifb.blank_out; tk = ifb.scan_tick; end
        default: begin en = ifc.digit_en; sel = ifc.sel; nib = ifc.nibble_out;
                 dpo = ifc.dp_out; bl = ifc.blank_out; tk = ifc.scan_tick; end
      endcase
      checks++;
      bad = (e.t != cyc) || (en !== e.en) || (sel !== e.sel) ||
            (bl !== e.blank) || (tk !== e.tick) ||
            (e.chk_data && ((nib !== e.nib) || (dpo !== e.dp)));
      if (bad) begin
        errors++;
        $display("FAIL dut%0d t=%0d: got en=%b sel=%0d nib=%h dp=%b blank=%b tick=%b, want en=%b sel=%0d nib=%h dp=%b blank=%b tick=%b (data checked=%b)",
                 e.id, e.t - base, en, sel, nib, dpo, bl, tk,
                 e.en, e.sel, e.nib, e.dp, e.blank, e.tick, e.chk_data);
      end
    end
  end

  initial begin
    step();
    step();

    // Phase 1: 0407 with dp on digit 1 and leading-zero suppression, two frames.
    data = 16'h0407; dp = 4'b0010; lz = 1'b1; enable = 1'b1;
    do_reset();
    for (int t = 0; t < 50; t++) begin
      hist[t] = {lz, dp, data};
      q.push_back(model(0, t, 4, 2, 1'b1));
      q.push_back(model(1, t, 3, 0, 1'b0));
      q.push_back(model(2, t, 4, 2, 1'b0));
      step();
    end

    // Phase 2: all zeros, then mid-dwell change to 0035 with suppression off.
    data = 16'h0000; dp = 4'b0000; lz = 1'b1;
    do_reset();
    for (int t = 0; t < 50; t++) begin
      if (t == 27) begin data = 16'h0035; dp = 4'b0100; lz = 1'b0; end
      hist[t] = {lz, dp, data};
      q.push_back(model(0, t, 4, 2, 1'b1));
      q.push_back(model(1, t, 3, 0, 1'b0));
      q.push_back(model(2, t, 4, 2, 1'b0));
      step();
    end

    // Phase 3: disable mid-dwell of digit 2, re-enable, then reset during digit 3.
    data = 16'h0407; dp = 4'b0010; lz = 1'b1; enable = 1'b1;
    do_reset();
    push_a(0,  4'b1111, 2'd0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    push_a(14, 4'b1011, 2'd2, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0);
    push_a(15, 4'b1011, 2'd2, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0);
    push_a(16, 4'b1111, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    push_a(20, 4'b1111, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    push_a(21, 4'b1111, 2'd2, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    push_a(22, 4'b1011, 2'd2, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0);
    push_a(25, 4'b1011, 2'd2, 1'b0, 1'b0, 1'b1, 4'h4, 1'b0);
    push_a(26, 4'b1111, 2'd3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    push_a(28, 4'b0111, 2'd3, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    push_a(29, 4'b0111, 2'd3, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    push_a(30, 4'b1111, 2'd0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0);
    push_a(31, 4'b1111, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    push_a(32, 4'b1110, 2'd0, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
    for (int t = 0; t < 34; t++) begin
      if (t == 15) enable = 1'b0;
      if (t == 20) enable = 1'b1;
      if (t == 29) reset = 1'b1;
      if (t == 30) reset = 1'b0;
      step();
    end

    step();
    step();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
